// File: rtl/cci_vec_rd_pkg.sv
// rtl/cci_vec_rd_pkg.sv - shared types and default widths for the vector-add read engine
package cci_vec_rd_pkg;

  localparam int ADDR_W_DEF    = 42;
  localparam int DATA_W_DEF    = 512;
  localparam int LEN_W_DEF     = 16;
  localparam int MAX_OUTST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_rd_state;

endpackage

// File: rtl/cci_rd_credit_ctr.sv
// rtl/cci_rd_credit_ctr.sv - up/down count of reads in flight with a full flag
module cci_rd_credit_ctr #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             inc_ok;

  assign full   = (count_q == CNT_W'(MAX_OUTST));
  assign count  = count_q;
  assign inc_ok = inc && !full;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_ok && dec) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cci_vec_rd_engine.sv
// rtl/cci_vec_rd_engine.sv - CCI-P channel-0 line reader writing out-of-order responses into the operand buffer
module cci_vec_rd_engine
  import cci_vec_rd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              stray_rsp,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]  rd_req_mdata,
  input  logic              rd_req_almfull,
  input  logic              rd_rsp_valid,
  input  logic [LEN_W-1:0]  rd_rsp_mdata,
  input  logic [DATA_W-1:0] rd_rsp_data,
  output logic              buf_wr_en,
  output logic [LEN_W-1:0]  buf_wr_idx,
  output logic [DATA_W-1:0] buf_wr_data
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  t_rd_state         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  num_q, num_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  recv_q, recv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stray_q, stray_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [LEN_W-1:0]  req_mdata_q, req_mdata_d;
  logic              wr_en_q, wr_en_d;
  logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              fire;
  logic              rsp_take;
  logic              credit_dec;
  logic              credit_full;
  logic [CNT_W-1:0]  credit_count;

  cci_rd_credit_ctr #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (fire),
    .dec   (credit_dec),
    .full  (credit_full),
    .count (credit_count)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q;
    recv_d      = recv_q;
    stray_d     = stray_q;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    req_mdata_d = req_mdata_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    fire        = 1'b0;
    rsp_take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_rsp_valid) stray_d = 1'b1;
        if (start) begin
          base_d   = base_addr;
          num_d    = num_lines;
          issued_d = '0;
          recv_d   = '0;
          stray_d  = 1'b0;
          state_d  = (num_lines == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rsp_take = rd_rsp_valid;
        fire     = !rd_req_almfull && !credit_full && (issued_q != num_q);
        if (issued_q == num_q) state_d = DRAIN;
      end
      DRAIN: begin
        rsp_take = rd_rsp_valid;
        if (recv_q == num_q) state_d = DONE;
      end
      DONE: begin
        if (rd_rsp_valid) stray_d = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (fire) begin
      req_valid_d = 1'b1;
      req_addr_d  = base_q + ADDR_W'(issued_q);
      req_mdata_d = issued_q;
      issued_d    = issued_q + LEN_W'(1);
    end

    // Responses are never back-pressured; mdata is trusted as the buffer index.
    if (rsp_take) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = rd_rsp_mdata;
      wr_data_d = rd_rsp_data;
      recv_d    = recv_q + LEN_W'(1);
    end

    credit_dec = rsp_take && (credit_count != '0);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      recv_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stray_q     <= 1'b0;
      req_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      recv_q      <= recv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stray_q     <= stray_d;
      req_valid_q <= req_valid_d;
      wr_en_q     <= wr_en_d;
    end
    req_addr_q  <= req_addr_d;
    req_mdata_q <= req_mdata_d;
    wr_idx_q    <= wr_idx_d;
    wr_data_q   <= wr_data_d;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign stray_rsp    = stray_q;
  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign buf_wr_en    = wr_en_q;
  assign buf_wr_idx   = wr_idx_q;
  assign buf_wr_data  = wr_data_q;

endmodule

// File: tb/tb_cci_vec_rd_engine.sv
// tb/tb_cci_vec_rd_engine.sv - randomized bench for cci_vec_rd_engine against a transaction-level model
module tb_cci_vec_rd_engine;

  localparam int ADDR_W    = 42;
  localparam int DATA_W    = 512;
  localparam int LEN_W     = 16;
  localparam int MAX_OUTST = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_lines;
  logic              busy, done, stray_rsp;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_req_mdata;
  logic              rd_req_almfull;
  logic              rd_rsp_valid;
  logic [LEN_W-1:0]  rd_rsp_mdata;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              buf_wr_en;
  logic [LEN_W-1:0]  buf_wr_idx;
  logic [DATA_W-1:0] buf_wr_data;

  always #5 clk = ~clk;

  cci_vec_rd_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .stray_rsp(stray_rsp),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_req_almfull(rd_req_almfull), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data), .buf_wr_en(buf_wr_en), .buf_wr_idx(buf_wr_idx), .buf_wr_data(buf_wr_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: job bookkeeping plus expected registered outputs.
  bit                m_live = 1'b0;
  bit                m_busy, m_done, m_stray, m_drain;
  logic [ADDR_W-1:0] m_base;
  int                m_n, m_issued, m_recv, m_outst;
  int                old_issued, old_recv;
  bit                m_fire, m_dec;
  bit                e_req, e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [LEN_W-1:0]  e_mdata, e_idx;
  logic [DATA_W-1:0] e_data;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_busy = 0; m_done = 0; m_stray = 0; m_drain = 0;
      m_issued = 0; m_recv = 0; m_outst = 0; e_req = 0; e_wr = 0;
    end else if (m_live) begin
      e_req = 0;
      e_wr  = 0;
      if (!m_busy) begin
        if (rd_rsp_valid) m_stray = 1;
        if (start) begin
          m_base = base_addr; m_n = int'(num_lines); m_issued = 0; m_recv = 0;
          m_stray = 0; m_drain = 0; m_busy = 1; m_done = (num_lines == 0);
        end
      end else if (m_done) begin
        m_busy = 0;
        m_done = 0;
        if (rd_rsp_valid) m_stray = 1;
      end else begin
        old_issued = m_issued;
        old_recv   = m_recv;
        m_fire = !m_drain && (m_issued < m_n) && !rd_req_almfull && (m_outst < MAX_OUTST);
        m_dec  = rd_rsp_valid && (m_outst > 0);
        if (m_fire) begin
          e_req = 1; e_addr = m_base + ADDR_W'(m_issued); e_mdata = LEN_W'(m_issued);
          m_issued++;
        end
        if (rd_rsp_valid) begin
          e_wr = 1; e_idx = rd_rsp_mdata; e_data = rd_rsp_data;
          m_recv++;
        end
        m_outst = m_outst + (m_fire ? 1 : 0) - (m_dec ? 1 : 0);
        if (!m_drain) begin
          if (old_issued == m_n) m_drain = 1;
        end else if (old_recv == m_n) begin
          m_done = 1;
        end
      end
    end
  end

  int                req_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [LEN_W-1:0]  idx_log[$];
  logic [LEN_W-1:0]  pending[$];

  always @(negedge clk) begin
    if (m_live) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("stray_rsp", stray_rsp, m_stray);
      check("rd_req_valid", rd_req_valid, e_req);
      if (e_req) begin
        check("rd_req_addr", rd_req_addr, e_addr);
        check("rd_req_mdata", rd_req_mdata, e_mdata);
      end
      check("buf_wr_en", buf_wr_en, e_wr);
      if (e_wr) begin
        check("buf_wr_idx", buf_wr_idx, e_idx);
        check("buf_wr_data", buf_wr_data, e_data);
      end
      if (rd_req_valid) begin
        req_cnt++;
        addr_log.push_back(rd_req_addr);
        pending.push_back(rd_req_mdata);
      end
      if (buf_wr_en) begin
        wr_cnt++;
        idx_log.push_back(buf_wr_idx);
      end
      if (done) done_cnt++;
    end
  end

  // Responder: 0 withhold, 1 in order, 2 random pick, 3 scripted order.
  int               rsp_mode = 0;
  int               rsp_pct  = 100;
  int               alm_pct  = 0;
  logic [LEN_W-1:0] order_q[$];

  task automatic step();
    int k;
    @(posedge clk);
    #1;
    start        = 1'b0;
    rd_rsp_valid = 1'b0;
    k = -1;
    if (pending.size() > 0) begin
      if (rsp_mode == 1) k = 0;
      else if (rsp_mode == 2 && $urandom_range(0, 99) < rsp_pct) k = $urandom_range(0, pending.size() - 1);
      else if (rsp_mode == 3 && order_q.size() > 0) begin
        foreach (pending[i]) if (pending[i] == order_q[0]) k = i;
        if (k >= 0) void'(order_q.pop_front());
      end
    end
    if (k >= 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = pending[k];
      for (int w = 0; w < DATA_W / 32; w++) rd_rsp_data[w*32 +: 32] = $urandom();
      pending.delete(k);
    end
    if (alm_pct > 0) rd_req_almfull = ($urandom_range(0, 99) < alm_pct);
  endtask

  task automatic go(input logic [ADDR_W-1:0] b, input int n);
    start     = 1'b1;
    base_addr = b;
    num_lines = LEN_W'(n);
    step();
  endtask

  task automatic wait_done(input string nm, input int limit);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      if (done_cnt > d0) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual no done required done within %0d cycles", nm, limit);
    end
    repeat (2) step();
  endtask

  int                r0, w0, d0, a0, i0;
  logic [63:0]       rnd64;
  logic [ADDR_W-1:0] rb;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
    rd_req_almfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stray", stray_rsp, 0);
    check("reset_req_valid", rd_req_valid, 0);
    check("reset_wr_en", buf_wr_en, 0);
    reset = 1'b0;
    step();

    // T1: in-order, contiguous addresses from 0x1000
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt; a0 = addr_log.size(); i0 = idx_log.size();
    rsp_mode = 1;
    go(42'h1000, 4);
    wait_done("t1", 100);
    check("t1_req_count", req_cnt - r0, 4);
    check("t1_wr_count", wr_cnt - w0, 4);
    check("t1_done_count", done_cnt - d0, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", addr_log[a0 + i], 42'h1000 + 42'(i));
      check("t1_idx", idx_log[i0 + i], 16'(i));
    end

    // T2: credit limit with responses withheld
    rsp_mode = 0;
    r0 = req_cnt; w0 = wr_cnt;
    go(42'h2000, 16);
    repeat (30) step();
    check("t2_stall_req_count", req_cnt - r0, 8);
    rsp_mode = 1;
    step();
    rsp_mode = 0;
    repeat (6) step();
    check("t2_release_req_count", req_cnt - r0, 9);
    rsp_mode = 2; rsp_pct = 70;
    wait_done("t2", 400);
    check("t2_wr_count", wr_cnt - w0, 16);

    // T3: scripted out-of-order return
    rsp_mode = 0;
    i0 = idx_log.size(); d0 = done_cnt;
    go(42'h3000, 4);
    repeat (8) step();
    order_q = '{16'd3, 16'd1, 16'd0, 16'd2};
    rsp_mode = 3;
    wait_done("t3", 100);
    check("t3_idx0", idx_log[i0 + 0], 3);
    check("t3_idx1", idx_log[i0 + 1], 1);
    check("t3_idx2", idx_log[i0 + 2], 0);
    check("t3_idx3", idx_log[i0 + 3], 2);
    check("t3_done_count", done_cnt - d0, 1);

    // T4: almfull held 10 cycles mid-issue
    rsp_mode = 2; rsp_pct = 60;
    a0 = addr_log.size(); r0 = req_cnt;
    go(42'h4000, 24);
    for (int i = 0; i < 50 && (req_cnt - r0) < 3; i++) step();
    rd_req_almfull = 1'b1;
    step();
    r0 = req_cnt;
    repeat (9) step();
    rd_req_almfull = 1'b0;
    step();
    check("t4_hold_req_count", req_cnt - r0, 0);
    wait_done("t4", 600);
    check("t4_total_reqs", addr_log.size() - a0, 24);
    for (int i = 0; i < 24 && a0 + i < addr_log.size(); i++)
      check("t4_addr", addr_log[a0 + i], 42'h4000 + 42'(i));

    // T5: zero-length job, then start while busy
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    go(42'h5000, 0);
    wait_done("t5_zero", 10);
    check("t5_zero_reqs", req_cnt - r0, 0);
    check("t5_zero_wrs", wr_cnt - w0, 0);
    check("t5_zero_done", done_cnt - d0, 1);
    rsp_mode = 1;
    r0 = req_cnt; d0 = done_cnt;
    go(42'h6000, 3);
    step();
    go(42'h7000, 5);
    wait_done("t5_busy", 100);
    repeat (10) step();
    check("t5_busy_done_count", done_cnt - d0, 1);
    check("t5_busy_req_count", req_cnt - r0, 3);

    // T6: reset with two reads in flight
    rsp_mode = 0;
    rd_req_almfull = 1'b1;
    r0 = req_cnt; w0 = wr_cnt;
    go(42'h8000, 4);
    rd_req_almfull = 1'b0;
    repeat (2) step();
    rd_req_almfull = 1'b1;
    repeat (2) step();
    check("t6_issued_before_reset", req_cnt - r0, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_req_almfull = 1'b0;
    rsp_mode = 1;
    repeat (4) step();
    check("t6_stray_wrs", wr_cnt - w0, 0);
    check("t6_stray_flag", stray_rsp, 1);
    go(42'h9000, 1);
    check("t6_stray_cleared", stray_rsp, 0);
    wait_done("t6", 100);

    // Randomized jobs, including an address that wraps
    for (int r = 0; r < 8; r++) begin
      rnd64 = {$urandom(), $urandom()};
      rb = (r == 0) ? 42'h3FF_FFFF_FFFD : rnd64[ADDR_W-1:0];
      rsp_mode = 2;
      rsp_pct  = $urandom_range(30, 100);
      alm_pct  = $urandom_range(0, 40);
      w0 = wr_cnt;
      go(rb, (r == 0) ? 6 : $urandom_range(1, 40));
      wait_done("rand", 4000);
      alm_pct = 0;
      rd_req_almfull = 1'b0;
      check("rand_all_written", wr_cnt - w0, int'(num_lines));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
